// File: rtl/lock_pkg.sv
// Shared types and encodings for the lock chamber controller.
package lock_pkg;

  // Width of the water-level bus (levels 0..15).
  localparam int LEVEL_W = 4;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    ARR_FILL  = 4'd1,
    ARR_OUTER = 4'd2,
    ARR_DRAIN = 4'd3,
    ARR_INNER = 4'd4,
    DEP_DRAIN = 4'd5,
    DEP_INNER = 4'd6,
    DEP_FILL  = 4'd7,
    DEP_OUTER = 4'd8
  } state_t;

  // Encodings driven on bathysphereSignal.
  localparam logic [1:0] SIG_IDLE = 2'b00;
  localparam logic [1:0] SIG_ARR  = 2'b01;
  localparam logic [1:0] SIG_DEP  = 2'b10;

  // Direction code shown downstream for a given state.
  function automatic logic [1:0] sig_of(input state_t s);
    logic [1:0] sig;
    sig = SIG_IDLE;
    case (s)
      ARR_FILL, ARR_OUTER, ARR_DRAIN, ARR_INNER: sig = SIG_ARR;
      DEP_DRAIN, DEP_INNER, DEP_FILL, DEP_OUTER: sig = SIG_DEP;
      default:                                   sig = SIG_IDLE;
    endcase
    return sig;
  endfunction

endpackage

// File: rtl/level_stepper.sv
// Water-level stepper: moves the level one unit every STEP_CYCLES enabled
// cycles, saturating at 0 and LEVEL_MAX. The step timer is a down-counter that
// reloads whenever the level is not actively moving, so every fill/drain
// phase starts with a full step period.
module level_stepper
  import lock_pkg::*;
#(
  parameter int LEVEL_MAX   = 7,
  parameter int STEP_CYCLES = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               up,
  input  logic               down,
  input  logic               enable,
  output logic [LEVEL_W-1:0] level,
  output logic               atMax,
  output logic               atZero
);

  localparam int                 CNT_W    = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(STEP_CYCLES - 1);
  localparam logic [LEVEL_W-1:0] LVL_TOP  = LEVEL_W'(LEVEL_MAX);

  logic [LEVEL_W-1:0] r_level;
  logic [CNT_W-1:0]   r_cnt;
  logic               w_go_up;
  logic               w_go_dn;

  assign w_go_up = enable && up && (r_level != LVL_TOP);
  assign w_go_dn = enable && down && !up && (r_level != '0);

  // Step timer and saturating level register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_level <= '0;
      r_cnt   <= CNT_LOAD;
    end else if (!(w_go_up || w_go_dn)) begin
      r_cnt <= CNT_LOAD;
    end else if (r_cnt == '0) begin
      r_cnt   <= CNT_LOAD;
      r_level <= w_go_up ? (r_level + 1'b1) : (r_level - 1'b1);
    end else begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign level  = r_level;
  assign atMax  = (r_level == LVL_TOP);
  assign atZero = (r_level == '0);

endmodule

// File: rtl/lock_chamber_ctrl.sv
// Lock chamber controller: sequences water level and the two gates for
// bathysphere arrivals (sea -> dock) and departures (dock -> sea).
// Optional build macro LOCK_TIMEOUT_EN adds a watchdog on the gate-wait
// states that closes the gate, pulses fault and returns to IDLE.
//
// state     | meaning
// IDLE      | chamber at rest, arbitrating requests
// ARR_FILL  | arrival: raising level to sea level
// ARR_OUTER | arrival: outer gate open, waiting for bathysphere inside
// ARR_DRAIN | arrival: lowering level to dock level
// ARR_INNER | arrival: inner gate open, waiting for bathysphere to leave
// DEP_DRAIN | departure: lowering level to dock level
// DEP_INNER | departure: inner gate open, waiting for bathysphere inside
// DEP_FILL  | departure: raising level to sea level
// DEP_OUTER | departure: outer gate open, waiting for bathysphere to leave
module lock_chamber_ctrl
  import lock_pkg::*;
#(
  parameter int LEVEL_MAX      = 7,
  parameter int STEP_CYCLES    = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               arriveReq,
  input  logic               departReq,
  input  logic               bathIn,
  output logic [1:0]         bathysphereSignal,
  output logic               outerGateOpen,
  output logic               innerGateOpen,
  output logic [LEVEL_W-1:0] waterLevel,
  output logic               fault
);

  if (LEVEL_MAX < 1 || LEVEL_MAX > 15 || STEP_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("lock_chamber_ctrl: parameter out of range");
  end

  state_t     r_state;
  state_t     w_state_nxt;
  logic [1:0] r_sig;
  logic       r_outer;
  logic       r_inner;
  logic       r_fault;
  logic       r_pend_arr;
  logic       r_pend_dep;
  logic       r_last_arr;   // 1 when the most recent grant went to arrival
  logic       w_want_arr;
  logic       w_want_dep;
  logic       w_grant_arr;
  logic       w_grant_dep;
  logic       w_fault_nxt;
  logic       w_wd_fire;
  logic       w_fill;
  logic       w_drain;
  logic       w_at_max;
  logic       w_at_zero;

  assign w_fill  = (r_state == ARR_FILL)  || (r_state == DEP_FILL);
  assign w_drain = (r_state == ARR_DRAIN) || (r_state == DEP_DRAIN);

  level_stepper #(
    .LEVEL_MAX   (LEVEL_MAX),
    .STEP_CYCLES (STEP_CYCLES)
  ) u_stepper (
    .clk    (clk),
    .reset  (reset),
    .up     (w_fill),
    .down   (w_drain),
    .enable (w_fill || w_drain),
    .level  (waterLevel),
    .atMax  (w_at_max),
    .atZero (w_at_zero)
  );

`ifdef LOCK_TIMEOUT_EN
  localparam int              WD_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] r_wdog;
  logic            w_wait;

  // Gate-wait states are never entered back-to-back, so reloading while
  // outside them gives each wait a fresh budget.
  assign w_wait = (r_state == ARR_OUTER) || (r_state == ARR_INNER) ||
                  (r_state == DEP_INNER) || (r_state == DEP_OUTER);

  // Watchdog down-counter, fires on the last permitted wait cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)             r_wdog <= WD_LOAD;
    else if (!w_wait)       r_wdog <= WD_LOAD;
    else if (r_wdog != '0)  r_wdog <= r_wdog - 1'b1;
  end

  assign w_wd_fire = w_wait && (r_wdog == '0);
`else
  assign w_wd_fire = 1'b0;
`endif

  assign w_want_arr = arriveReq || r_pend_arr;
  assign w_want_dep = departReq || r_pend_dep;

  // Next-state, arbitration and watchdog abort decisions.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_arr = 1'b0;
    w_grant_dep = 1'b0;
    w_fault_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_want_arr && (!w_want_dep || !r_last_arr)) begin
          w_grant_arr = 1'b1;
          w_state_nxt = ARR_FILL;
        end else if (w_want_dep) begin
          w_grant_dep = 1'b1;
          w_state_nxt = DEP_DRAIN;
        end
      end
      ARR_FILL:  if (w_at_max)  w_state_nxt = ARR_OUTER;
      ARR_OUTER: begin
        if (bathIn) w_state_nxt = ARR_DRAIN;
        else if (w_wd_fire) begin
          w_state_nxt = IDLE;
          w_fault_nxt = 1'b1;
        end
      end
      ARR_DRAIN: if (w_at_zero) w_state_nxt = ARR_INNER;
      ARR_INNER: begin
        if (!bathIn) w_state_nxt = IDLE;
        else if (w_wd_fire) begin
          w_state_nxt = IDLE;
          w_fault_nxt = 1'b1;
        end
      end
      DEP_DRAIN: if (w_at_zero) w_state_nxt = DEP_INNER;
      DEP_INNER: begin
        if (bathIn) w_state_nxt = DEP_FILL;
        else if (w_wd_fire) begin
          w_state_nxt = IDLE;
          w_fault_nxt = 1'b1;
        end
      end
      DEP_FILL:  if (w_at_max)  w_state_nxt = DEP_OUTER;
      DEP_OUTER: begin
        if (!bathIn) w_state_nxt = IDLE;
        else if (w_wd_fire) begin
          w_state_nxt = IDLE;
          w_fault_nxt = 1'b1;
        end
      end
      default:   w_state_nxt = IDLE;
    endcase
  end

  // State register with outputs registered from the next state so they
  // change on the same edge as the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_sig   <= SIG_IDLE;
      r_outer <= 1'b0;
      r_inner <= 1'b0;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sig   <= sig_of(w_state_nxt);
      r_outer <= (w_state_nxt == ARR_OUTER) || (w_state_nxt == DEP_OUTER);
      r_inner <= (w_state_nxt == ARR_INNER) || (w_state_nxt == DEP_INNER);
      r_fault <= w_fault_nxt;
    end
  end

  // Pending request flags (repeats merge) and last-served direction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pend_arr <= 1'b0;
      r_pend_dep <= 1'b0;
      r_last_arr <= 1'b0;
    end else begin
      r_pend_arr <= (r_pend_arr || arriveReq) && !w_grant_arr;
      r_pend_dep <= (r_pend_dep || departReq) && !w_grant_dep;
      if (w_grant_arr)      r_last_arr <= 1'b1;
      else if (w_grant_dep) r_last_arr <= 1'b0;
    end
  end

  assign bathysphereSignal = r_sig;
  assign outerGateOpen     = r_outer;
  assign innerGateOpen     = r_inner;
  assign fault             = r_fault;

endmodule

// File: tb/tb_lock_chamber_ctrl.sv
// Bench for lock_chamber_ctrl with LEVEL_MAX=3, STEP_CYCLES=2,
// TIMEOUT_CYCLES=10. Watchdog scenario is built only with LOCK_TIMEOUT_EN.
module tb_lock_chamber_ctrl;

  localparam int LMAX = 3;
  localparam int STEP = 2;
  localparam int TOUT = 10;

  localparam logic [1:0] SI = 2'b00;
  localparam logic [1:0] SA = 2'b01;
  localparam logic [1:0] SD = 2'b10;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       arr, dep, bath;
  logic [1:0] sig;
  logic       outer, inner, fault;
  logic [3:0] lvl;
  logic [3:0] prev_lvl;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc_cnt = 0;

  typedef struct {
    string      tag;
    logic [8:0] exp;
    int         due;
  } sb_t;
  sb_t sb_q[$];

  lock_chamber_ctrl #(
    .LEVEL_MAX      (LMAX),
    .STEP_CYCLES    (STEP),
    .TIMEOUT_CYCLES (TOUT)
  ) dut (
    .clk               (clk),
    .reset             (rst_n),
    .arriveReq         (arr),
    .departReq         (dep),
    .bathIn            (bath),
    .bathysphereSignal (sig),
    .outerGateOpen     (outer),
    .innerGateOpen     (inner),
    .waterLevel        (lvl),
    .fault             (fault)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Packed observation: {fault, signal, outer, inner, level}.
  function automatic logic [8:0] obs(input logic [1:0] s, input logic o, input logic i,
                                     input int l, input logic f = 1'b0);
    return {f, s, o, i, 4'(l)};
  endfunction

  // One cycle of stimulus; exp is what the outputs must show after the
  // rising edge that ends this cycle.
  task automatic cyc(input logic a, input logic d, input logic b,
                     input logic [8:0] exp, input string tag);
    sb_t e;
    @(negedge clk);
    arr  = a;
    dep  = d;
    bath = b;
    e.tag = tag;
    e.exp = exp;
    e.due = cyc_cnt + 1;
    sb_q.push_back(e);
  endtask

  // Level ramp after the entry cycle: one unit per STEP cycles.
  task automatic ramp(input logic [1:0] s, input int from, input int to, input logic b,
                      input int dpulses, input string tag);
    int n;
    n = (to > from) ? (to - from) : (from - to);
    for (int j = 1; j <= n * STEP; j++) begin
      int lv;
      lv = (to > from) ? (from + j / STEP) : (from - j / STEP);
      cyc(1'b0, (j <= dpulses), b, obs(s, 1'b0, 1'b0, lv), tag);
    end
  endtask

  task automatic run_arrival(input logic a, input logic d, input int lvl0, input int dp,
                             input string tag);
    cyc(a, d, 1'b0, obs(SA, 0, 0, lvl0), {tag, "_entry"});
    ramp(SA, lvl0, LMAX, 1'b0, dp, {tag, "_fill"});
    cyc(0, 0, 0, obs(SA, 1, 0, LMAX), {tag, "_outer"});
    cyc(0, 0, 0, obs(SA, 1, 0, LMAX), {tag, "_outer_hold"});
    cyc(0, 0, 1, obs(SA, 0, 0, LMAX), {tag, "_drain0"});
    ramp(SA, LMAX, 0, 1'b1, 0, {tag, "_drain"});
    cyc(0, 0, 1, obs(SA, 0, 1, 0), {tag, "_inner"});
    cyc(0, 0, 0, obs(SI, 0, 0, 0), {tag, "_idle"});
  endtask

  task automatic run_departure(input logic a, input logic d, input int lvl0, input string tag);
    cyc(a, d, 1'b0, obs(SD, 0, 0, lvl0), {tag, "_entry"});
    ramp(SD, lvl0, 0, 1'b0, 0, {tag, "_drain"});
    cyc(0, 0, 0, obs(SD, 0, 1, 0), {tag, "_inner"});
    cyc(0, 0, 1, obs(SD, 0, 0, 0), {tag, "_fill0"});
    ramp(SD, 0, LMAX, 1'b1, 0, {tag, "_fill"});
    cyc(0, 0, 1, obs(SD, 1, 0, LMAX), {tag, "_outer"});
    cyc(0, 0, 0, obs(SI, 0, 0, LMAX), {tag, "_idle"});
  endtask

  // Scoreboard pop plus gate-safety checks on every falling edge.
  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].due <= cyc_cnt) begin
      sb_t e;
      e = sb_q.pop_front();
      chk_eq(e.tag, {fault, sig, outer, inner, lvl}, e.exp);
    end
    if (rst_n && (outer || inner)) begin
      chk_eq("gate_excl", outer && inner, 0);
      chk_eq("gate_lvl_still", lvl, prev_lvl);
    end
    prev_lvl <= lvl;
  end

  a_excl: assert property (@(posedge clk) disable iff (!rst_n) !(outer && inner))
    else $error("FAIL a_excl: both gates open");
  a_still: assert property (@(posedge clk) disable iff (!rst_n) (outer || inner) |-> $stable(lvl))
    else $error("FAIL a_still: level moved with a gate open");

  initial begin
    #500000;
    $display("FAIL tb_timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    arr   = 1'b0;
    dep   = 1'b0;
    bath  = 1'b0;
    repeat (3) @(negedge clk);
    chk_eq("rst_sig",   sig,   SI);
    chk_eq("rst_outer", outer, 0);
    chk_eq("rst_inner", inner, 0);
    chk_eq("rst_lvl",   lvl,   0);
    chk_eq("rst_fault", fault, 0);
    rst_n = 1'b1;

    // Arrival from reset, then departure with level already at zero.
    run_arrival(1, 0, 0, 0, "arr1");
    run_departure(0, 1, 0, "dep1");

    // Simultaneous requests, departure served last: arrival wins, fill at max.
    run_arrival(1, 1, LMAX, 0, "tie_a");
    run_departure(0, 0, 0, "tie_a_dep");

    // Simultaneous requests, arrival served last: departure wins.
    run_arrival(1, 0, LMAX, 0, "arr2");
    run_departure(1, 1, 0, "tie_d");
    run_arrival(0, 0, LMAX, 0, "tie_d_arr");

    // Repeated departure requests during an arrival merge into one.
    run_arrival(1, 0, 0, 2, "merge");
    run_departure(0, 0, 0, "merge_dep");
    repeat (3) cyc(0, 0, 0, obs(SI, 0, 0, LMAX), "merge_once");

    // Reset mid-drain at level 2 with a departure pending.
    cyc(1, 0, 0, obs(SA, 0, 0, 3), "rs_entry");
    cyc(0, 0, 0, obs(SA, 1, 0, 3), "rs_outer");
    cyc(0, 1, 1, obs(SA, 0, 0, 3), "rs_drain0");
    cyc(0, 0, 1, obs(SA, 0, 0, 3), "rs_drain1");
    cyc(0, 0, 1, obs(SA, 0, 0, 2), "rs_drain2");
    @(negedge clk);
    #2;
    chk_eq("rs_pre_lvl", lvl, 2);
    rst_n = 1'b0;
    #1;
    chk_eq("rs_lvl",   lvl,   0);
    chk_eq("rs_outer", outer, 0);
    chk_eq("rs_inner", inner, 0);
    chk_eq("rs_sig",   sig,   SI);
    arr  = 1'b0;
    dep  = 1'b0;
    bath = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) cyc(0, 0, 0, obs(SI, 0, 0, 0), "rs_no_pend");

`ifdef LOCK_TIMEOUT_EN
    // Outer gate wait with no bathysphere: abort after TOUT cycles.
    cyc(1, 0, 0, obs(SA, 0, 0, 0), "to_entry");
    ramp(SA, 0, LMAX, 1'b0, 0, "to_fill");
    cyc(0, 0, 0, obs(SA, 1, 0, LMAX), "to_outer");
    for (int k = 1; k < TOUT; k++) cyc(0, 0, 0, obs(SA, 1, 0, LMAX), "to_wait");
    cyc(0, 0, 0, obs(SI, 0, 0, LMAX, 1'b1), "to_fault");
    cyc(0, 0, 0, obs(SI, 0, 0, LMAX, 1'b0), "to_after");
`endif

    // Random requests and sensor activity; gate safety checked by monitor.
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      arr = ($urandom_range(0, 15) == 0);
      dep = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 7) == 0) bath = ~bath;
    end
    @(negedge clk);
    arr = 1'b0;
    dep = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk_eq("sb_drained", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lock_chamber_ctrl.md
LOCK_CHAMBER_CTRL -- requirements
Module: lock_chamber_ctrl

Interface
REQ-001 Parameter LEVEL_MAX, default 7: water level when the chamber is full; range 1..15.
REQ-002 Parameter STEP_CYCLES, default 4: clock cycles per one-unit water-level change; minimum 1.
REQ-003 Parameter TIMEOUT_CYCLES, default 255: watchdog limit in the gate-wait states; used only with LOCK_TIMEOUT_EN.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 arriveReq  input  1  one-cycle pulse: a bathysphere is waiting at the sea (outer) gate.
REQ-007 departReq  input  1  one-cycle pulse: a bathysphere is waiting at the dock (inner) gate.
REQ-008 bathIn  input  1  level sensor: a bathysphere is inside the chamber.
REQ-009 bathysphereSignal  output  2  bit1 = departing, bit0 = arriving; 00 when idle; feeds the downstream display stage.
REQ-010 outerGateOpen, innerGateOpen  output  1 each  gate commands.
REQ-011 waterLevel  output  4  current level, 0 to LEVEL_MAX.
REQ-012 fault  output  1  one-cycle pulse on watchdog abort; tied to 0 without LOCK_TIMEOUT_EN.

Function
REQ-013 The FSM states shall be: IDLE, ARR_FILL, ARR_OUTER, ARR_DRAIN, ARR_INNER, DEP_DRAIN, DEP_INNER, DEP_FILL, DEP_OUTER.
REQ-014 Arrival sequence:
- IDLE → ARR_FILL.
- ARR_FILL → ARR_OUTER when waterLevel == LEVEL_MAX.
- ARR_OUTER → ARR_DRAIN on bathIn == 1.
- ARR_DRAIN → ARR_INNER when waterLevel == 0.
- ARR_INNER → IDLE on bathIn == 0.
REQ-015 Departure sequence:
- IDLE → DEP_DRAIN.
- DEP_DRAIN → DEP_INNER when waterLevel == 0.
- DEP_INNER → DEP_FILL on bathIn == 1.
- DEP_FILL → DEP_OUTER when waterLevel == LEVEL_MAX.
- DEP_OUTER → IDLE on bathIn == 0.
REQ-016 In FILL states, waterLevel shall increment by 1 every STEP_CYCLES cycles; in DRAIN states it shall decrement by 1; it shall saturate at LEVEL_MAX and at 0, never wrapping.
REQ-017 When a FILL or DRAIN state is entered with the level already at its target, the state shall exit on the next cycle.
REQ-018 outerGateOpen shall be 1 only in ARR_OUTER and DEP_OUTER; innerGateOpen shall be 1 only in ARR_INNER and DEP_INNER; both outputs shall be registered.
REQ-019 Both gates shall never be open in the same cycle, and the gates shall never open while waterLevel is changing.
REQ-020 bathysphereSignal shall be 01 in all ARR_* states, 10 in all DEP_* states, 00 in IDLE, registered and updated in the same cycle as the state.
REQ-021 Requests arriving outside IDLE shall be latched in one pending flag per direction; a repeated request of the same direction shall merge into the existing flag.
REQ-022 In IDLE with both directions pending or requested in the same cycle, the direction not served last shall win; the first grant after reset shall go to arrival.
REQ-023 A pending flag shall clear in the cycle its sequence starts; IDLE with a pending flag shall start that sequence on the next cycle, with no idle gap beyond one cycle.

Reset
REQ-024 While reset is low, outputs shall be:
- state IDLE;
- waterLevel = 0;
- both gates = 0;
- bathysphereSignal = 00;
- fault = 0;
- pending flags, step counter, watchdog and last-served flag cleared.
REQ-025 A reset asserted mid-sequence shall abort the sequence immediately; no request shall be remembered across reset.

Configuration
REQ-026 Macro LOCK_TIMEOUT_EN:
- Defined: in ARR_OUTER, ARR_INNER, DEP_INNER and DEP_OUTER, when the awaited bathIn edge is absent for TIMEOUT_CYCLES cycles, the block shall close the gate, pulse fault for 1 cycle, return to IDLE and keep waterLevel unchanged.
- Undefined: no watchdog logic, fault tied to 0, and the gate-wait states wait indefinitely.

Structure
REQ-027 The shared package lock_pkg shall hold the state enumeration, the SIG_IDLE/SIG_ARR/SIG_DEP 2-bit encodings, and the level width constant.
REQ-028 The level stepping shall be one sub-module, level_stepper (inputs up/down/enable; outputs level, atMax, atZero), parameterised by LEVEL_MAX and STEP_CYCLES.

Verification (LEVEL_MAX=3, STEP_CYCLES=2, TIMEOUT_CYCLES=10)
REQ-029 Arrival from reset: arriveReq pulse gives bathysphereSignal=01 on the next edge and the level rising 0→3 over 6 cycles, then outerGateOpen=1; bathIn=1 gives outer closed and the level falling 3→0 over 6 cycles, then innerGateOpen=1; bathIn=0 gives IDLE with signal 00.
REQ-030 Simultaneous arriveReq and departReq in IDLE: arrival runs first; departure starts one cycle after the arrival returns to IDLE, with signal 10.
REQ-031 departReq with level already 0: DEP_DRAIN lasts 1 cycle, then innerGateOpen=1.
REQ-032 reset driven low during ARR_DRAIN at level 2: the same cycle, with no clock edge, shows level 0, gates 0, signal 00, and the pending departure is discarded.
REQ-033 With LOCK_TIMEOUT_EN defined, ARR_OUTER with bathIn held 0 for 10 cycles: one-cycle fault pulse, outerGateOpen=0, IDLE, level stays 3.
REQ-034 A 10,000-cycle random run of requests and sensor activity: assertion that the two gates are never open together and neither is open while the level is changing.
